// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the M-stage load/store unit and memory.
// Request/grant on the way out, rvalid/rdata/err coming back.
interface mem_access_unit_if;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        dmem_err_i;

    modport master (
        output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
        input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i, dmem_err_i
    );

    modport slave (
        input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
        output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i, dmem_err_i
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: turns M-stage load/store control into a bus
// transaction, stalls until it completes and formats the returned load data.
module mem_access_unit #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ValidM,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] RdataM,
    output logic        StallM,
    output logic        LoadMisalignM,
    output logic        StoreMisalignM,
    output logic        AccessFaultM,
    mem_access_unit_if.master dmem
);

    localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
    logic            fault_q, fault_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            req_q, req_d, we_q, we_d;
    logic [31:0]     addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]      be_q, be_d;

    logic        access, unsupported, misalign, legal, timeout;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc, lane, load_fmt;

    assign access      = ValidM & (MemReadM | MemWriteM);
    assign unsupported = MemReadM ? (Funct3M == 3'd3 || Funct3M == 3'd6 || Funct3M == 3'd7)
                                  : (Funct3M >= 3'd3);
    // H and HU share Funct3M[1:0]=01; only W (2) needs full word alignment.
    assign misalign    = ~unsupported &
                         (((Funct3M[1:0] == 2'b01) & ALUResultM[0]) |
                          ((Funct3M == 3'd2) & (ALUResultM[1:0] != 2'b00)));
    assign legal       = access & ~misalign & ~unsupported;

    assign LoadMisalignM  = access & MemReadM & misalign;
    assign StoreMisalignM = access & MemWriteM & misalign;
    assign AccessFaultM   = (state_q == StResp) ? fault_q
                          : ((state_q == StIdle) & access & unsupported);
    assign StallM         = (state_q == StIdle) ? legal
                          : ((state_q == StReq) | (state_q == StWait));

    assign cnt_inc = cnt_q + 1'b1;
    assign timeout = (cnt_inc == CntW'(MAX_WAIT));

    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = WriteDataM;
        unique case (Funct3M[1:0])
            2'b00: begin
                be_calc    = 4'b0001 << ALUResultM[1:0];
                wdata_calc = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                be_calc    = ALUResultM[1] ? 4'b1100 : 4'b0011;
                wdata_calc = {2{WriteDataM[15:0]}};
            end
            default: ;
        endcase
    end

    assign lane = dmem.dmem_rdata_i >> {ALUResultM[1:0], 3'b000};

    always_comb begin
        load_fmt = lane;
        case (Funct3M)
            3'd0:    load_fmt = {{24{lane[7]}}, lane[7:0]};
            3'd1:    load_fmt = {{16{lane[15]}}, lane[15:0]};
            3'd4:    load_fmt = {24'b0, lane[7:0]};
            3'd5:    load_fmt = {16'b0, lane[15:0]};
            default: load_fmt = lane;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        rdata_d = rdata_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        unique case (state_q)
            StIdle: begin
                if (legal) begin
                    req_d   = 1'b1;
                    we_d    = MemWriteM;
                    addr_d  = {ALUResultM[31:2], 2'b00};
                    be_d    = be_calc;
                    wdata_d = wdata_calc;
                    cnt_d   = '0;
                    fault_d = 1'b0;
                    state_d = StReq;
                end
            end
            StReq: begin
                cnt_d = cnt_inc;
                if (dmem.dmem_gnt_i) begin
                    req_d   = 1'b0;
                    state_d = StWait;
                end else if (timeout) begin
                    req_d   = 1'b0;
                    fault_d = 1'b1;
                    state_d = StResp;
                end
            end
            StWait: begin
                cnt_d = cnt_inc;
                if (dmem.dmem_rvalid_i) begin
                    if (MemReadM) rdata_d = load_fmt;
                    fault_d = dmem.dmem_err_i;
                    state_d = StResp;
                end else if (timeout) begin
                    if (MemReadM) rdata_d = '0;
                    fault_d = 1'b1;
                    state_d = StResp;
                end
            end
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            fault_q <= 1'b0;
            rdata_q <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
            rdata_q <= rdata_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
        end
    end

    assign RdataM            = rdata_q;
    assign dmem.dmem_req_o   = req_q;
    assign dmem.dmem_we_o    = we_q;
    assign dmem.dmem_addr_o  = addr_q;
    assign dmem.dmem_be_o    = be_q;
    assign dmem.dmem_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: one instance at default MAX_WAIT, one at
// MAX_WAIT=4 for timeout cases; both share pipeline and bus inputs except ValidM.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_a, valid_b, mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        gnt, rvalid, err;
    logic [31:0] rdata;

    logic [31:0] rdata_a, rdata_b;
    logic        stall_a, lmis_a, smis_a, fault_a;
    logic        stall_b, lmis_b, smis_b, fault_b;
    logic        req_a, req_b;

    int          n_checks = 0;
    int          n_errs = 0;
    int          stalls;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_we;

    always #5 clk = ~clk;

    mem_access_unit_if bus_a ();
    mem_access_unit_if bus_b ();

    assign bus_a.dmem_gnt_i    = gnt;
    assign bus_a.dmem_rvalid_i = rvalid;
    assign bus_a.dmem_rdata_i  = rdata;
    assign bus_a.dmem_err_i    = err;
    assign bus_b.dmem_gnt_i    = gnt;
    assign bus_b.dmem_rvalid_i = rvalid;
    assign bus_b.dmem_rdata_i  = rdata;
    assign bus_b.dmem_err_i    = err;
    assign req_a = bus_a.dmem_req_o;
    assign req_b = bus_b.dmem_req_o;

    mem_access_unit dut_a (
        .clk(clk), .rst_n(rst_n), .ValidM(valid_a), .MemReadM(mem_read),
        .MemWriteM(mem_write), .Funct3M(funct3), .ALUResultM(addr), .WriteDataM(wdata),
        .RdataM(rdata_a), .StallM(stall_a), .LoadMisalignM(lmis_a),
        .StoreMisalignM(smis_a), .AccessFaultM(fault_a), .dmem(bus_a)
    );

    mem_access_unit #(.MAX_WAIT(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .ValidM(valid_b), .MemReadM(mem_read),
        .MemWriteM(mem_write), .Funct3M(funct3), .ALUResultM(addr), .WriteDataM(wdata),
        .RdataM(rdata_b), .StallM(stall_b), .LoadMisalignM(lmis_b),
        .StoreMisalignM(smis_b), .AccessFaultM(fault_b), .dmem(bus_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic cur_stall(input bit sel);
        return sel ? stall_b : stall_a;
    endfunction

    function automatic logic cur_req(input bit sel);
        return sel ? req_b : req_a;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        valid_a = 1'b0;
        valid_b = 1'b0;
        step();
    endtask

    // Runs one access; grant comes gdly cycles into REQ, rvalid rdly cycles into WAIT
    // (rdly < 0: never). Returns positioned in the RESP cycle with inputs held.
    task automatic txn(input bit sel, input bit is_load, input logic [2:0] f3,
                       input logic [31:0] ad, input logic [31:0] wd, input int gdly,
                       input int rdly, input logic [31:0] rd, input logic e,
                       output int ns);
        int  g = 0;
        int  r = 0;
        int  c = 0;
        bit  granted = 0;
        valid_a = !sel; valid_b = sel;
        mem_read = is_load; mem_write = !is_load;
        funct3 = f3; addr = ad; wdata = wd; rdata = rd; err = e;
        ns = 0;
        #1;
        while (cur_stall(sel) && c < 300) begin
            ns++; c++;
            gnt = 1'b0; rvalid = 1'b0;
            if (cur_req(sel)) begin
                cap_we    = sel ? bus_b.dmem_we_o    : bus_a.dmem_we_o;
                cap_addr  = sel ? bus_b.dmem_addr_o  : bus_a.dmem_addr_o;
                cap_be    = sel ? bus_b.dmem_be_o    : bus_a.dmem_be_o;
                cap_wdata = sel ? bus_b.dmem_wdata_o : bus_a.dmem_wdata_o;
                gnt = (g == gdly);
                if (gnt) granted = 1;
                g++;
            end else if (granted) begin
                rvalid = (rdly >= 0 && r == rdly);
                r++;
            end
            step();
            gnt = 1'b0; rvalid = 1'b0;
        end
        n_checks++;
        assert (!cur_stall(sel)) else begin
            n_errs++;
            $error("FAIL txn_bound: observed stall still 1 expected 0");
        end
    endtask

    initial begin
        rst_n = 1'b0;
        valid_a = 0; valid_b = 0; mem_read = 0; mem_write = 0;
        funct3 = 0; addr = 0; wdata = 0;
        gnt = 0; rvalid = 0; err = 0; rdata = 0;
        cap_addr = 0; cap_wdata = 0; cap_be = 0; cap_we = 0;
        #12;
        chk("rst_req", req_a, 0);
        chk("rst_we", bus_a.dmem_we_o, 0);
        chk("rst_addr", bus_a.dmem_addr_o, 0);
        chk("rst_be", bus_a.dmem_be_o, 0);
        chk("rst_wdata", bus_a.dmem_wdata_o, 0);
        chk("rst_rdata", rdata_a, 0);
        chk("rst_stall", stall_a, 0);
        chk("rst_fault", fault_a, 0);
        rst_n = 1'b1;
        step();

        // LB, no wait
        txn(0, 1, 3'd0, 32'h1003, 0, 0, 0, 32'h80AABBCC, 0, stalls);
        chk("lb_stalls", stalls, 3);
        chk("lb_be", cap_be, 4'b1000);
        chk("lb_addr", cap_addr, 32'h1000);
        chk("lb_we", cap_we, 0);
        chk("lb_rdata", rdata_a, 32'hFFFFFF80);
        chk("lb_fault", fault_a, 0);
        chk("lb_req_resp", req_a, 0);
        idle();

        // SH
        txn(0, 0, 3'd1, 32'h2002, 32'h12345678, 0, 0, 32'hFFFFFFFF, 0, stalls);
        chk("sh_stalls", stalls, 3);
        chk("sh_we", cap_we, 1);
        chk("sh_be", cap_be, 4'b1100);
        chk("sh_wdata", cap_wdata, 32'h56785678);
        chk("sh_rdata_kept", rdata_a, 32'hFFFFFF80);
        idle();

        // SB lane replication
        txn(0, 0, 3'd0, 32'h2001, 32'h000000AB, 0, 0, 0, 0, stalls);
        chk("sb_be", cap_be, 4'b0010);
        chk("sb_wdata", cap_wdata, 32'hABABABAB);
        idle();

        // Misaligned LW then SH, unsupported funct3
        valid_a = 1; mem_read = 1; mem_write = 0; funct3 = 3'd2; addr = 32'h2001;
        #1;
        chk("lw_mis_flag", lmis_a, 1);
        chk("lw_mis_smis", smis_a, 0);
        chk("lw_mis_stall", stall_a, 0);
        step();
        chk("lw_mis_req", req_a, 0);
        mem_read = 0; mem_write = 1; funct3 = 3'd1; addr = 32'h2003;
        #1;
        chk("sh_mis_flag", smis_a, 1);
        chk("sh_mis_lmis", lmis_a, 0);
        chk("sh_mis_stall", stall_a, 0);
        step();
        chk("sh_mis_req", req_a, 0);
        mem_read = 1; mem_write = 0; funct3 = 3'd3; addr = 32'h2000;
        #1;
        chk("ld_f3_fault", fault_a, 1);
        chk("ld_f3_stall", stall_a, 0);
        step();
        chk("ld_f3_req", req_a, 0);
        mem_read = 0; mem_write = 1; funct3 = 3'd4;
        #1;
        chk("st_f3_fault", fault_a, 1);
        chk("st_f3_stall", stall_a, 0);
        idle();

        // LHU: 4 cycles without grant, then rvalid with bus error
        txn(0, 1, 3'd5, 32'h1002, 0, 4, 0, 32'hDEADBEEF, 1, stalls);
        chk("lhu_stalls", stalls, 7);
        chk("lhu_fault", fault_a, 1);
        chk("lhu_rdata", rdata_a, 32'h0000DEAD);
        idle();
        chk("lhu_fault_clr", fault_a, 0);

        txn(0, 1, 3'd1, 32'h1000, 0, 1, 2, 32'h12348001, 0, stalls);
        chk("lh_stalls", stalls, 6);
        chk("lh_rdata", rdata_a, 32'hFFFF8001);
        chk("lh_fault", fault_a, 0);
        idle();

        txn(0, 1, 3'd4, 32'h1001, 0, 0, 0, 32'h0000F000, 0, stalls);
        chk("lbu_stalls", stalls, 3);
        chk("lbu_rdata", rdata_a, 32'h000000F0);
        idle();

        // Timeout on the MAX_WAIT=4 instance
        txn(1, 1, 3'd2, 32'h3000, 0, 0, 0, 32'hCAFEF00D, 0, stalls);
        chk("b_lw_stalls", stalls, 3);
        chk("b_lw_rdata", rdata_b, 32'hCAFEF00D);
        idle();
        txn(1, 1, 3'd2, 32'h3004, 0, 0, -1, 32'h0, 0, stalls);
        chk("to_stalls", stalls, 5);
        chk("to_fault", fault_b, 1);
        chk("to_rdata", rdata_b, 0);
        chk("to_lmis", lmis_b, 0);
        idle();
        rvalid = 1; gnt = 1; rdata = 32'h11111111;
        step();
        rvalid = 0; gnt = 0;
        chk("stray_rdata", rdata_b, 0);
        chk("stray_stall", stall_b, 0);
        chk("stray_req", req_b, 0);
        chk("stray_fault", fault_b, 0);
        txn(1, 0, 3'd2, 32'h3008, 32'h1, 100, 0, 0, 0, stalls);
        chk("gto_stalls", stalls, 5);
        chk("gto_fault", fault_b, 1);
        chk("gto_req", req_b, 0);
        chk("gto_smis", smis_b, 0);
        idle();

        // Reset mid-WAIT on a store
        valid_a = 1; mem_read = 0; mem_write = 1; funct3 = 3'd2;
        addr = 32'h1004; wdata = 32'hA5A5A5A5;
        step();
        chk("rw_req", req_a, 1);
        gnt = 1;
        step();
        gnt = 0;
        chk("rw_wait_req", req_a, 0);
        chk("rw_wait_stall", stall_a, 1);
        chk("rw_wait_we", bus_a.dmem_we_o, 1);
        rst_n = 0; valid_a = 0;
        #1;
        chk("rw_we", bus_a.dmem_we_o, 0);
        chk("rw_be", bus_a.dmem_be_o, 0);
        chk("rw_addr", bus_a.dmem_addr_o, 0);
        chk("rw_wdata", bus_a.dmem_wdata_o, 0);
        chk("rw_rdata", rdata_a, 0);
        chk("rw_stall", stall_a, 0);
        rvalid = 1; rdata = 32'h77777777;
        step();
        rst_n = 1;
        step();
        rvalid = 0;
        chk("rw_late_stall", stall_a, 0);
        chk("rw_late_rdata", rdata_a, 0);
        txn(0, 1, 3'd2, 32'h1008, 0, 0, 0, 32'h01020304, 0, stalls);
        chk("rw_lw_stalls", stalls, 3);
        chk("rw_lw_rdata", rdata_a, 32'h01020304);
        idle();

        // Asynchronous drop of an active request
        valid_a = 1; mem_read = 1; mem_write = 0; funct3 = 3'd0; addr = 32'h1000;
        step();
        chk("rr_req", req_a, 1);
        rst_n = 0; valid_a = 0;
        #1;
        chk("rr_req_async", req_a, 0);
        rst_n = 1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage load/store unit of the five-stage RISC-V pipeline. It sits between the Execute/Memory register and the Memory/Writeback register. It turns the M-stage load/store control into a request/grant/response transaction on the data-memory bus, stalling the pipeline until the transaction completes. It also produces the aligned, sign- or zero-extended load data (`RdataM`) consumed by the Memory/Writeback register, and flags misaligned and faulting accesses.

## Interface
Parameters:
- `MAX_WAIT`, default 255: cycles spent in REQ+WAIT before a bus timeout is declared; must be ≥1.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ValidM` in 1: the M-stage slot holds a valid instruction.
- `MemReadM` in 1: the instruction is a load.
- `MemWriteM` in 1: the instruction is a store. `MemReadM` and `MemWriteM` are never both 1.
- `Funct3M` in 3: width/sign code. 0=B, 1=H, 2=W, 4=BU, 5=HU.
- `ALUResultM` in 32: effective byte address.
- `WriteDataM` in 32: store data, right-aligned.
- `RdataM` out 32: formatted load data, registered.
- `StallM` out 1: hold all pipeline registers at and before M.
- `LoadMisalignM` out 1: combinational misaligned-load flag.
- `StoreMisalignM` out 1: combinational misaligned-store flag.
- `AccessFaultM` out 1: bus error, timeout, or unsupported `Funct3M`.
- `dmem_req_o` out 1: bus request, registered.
- `dmem_we_o` out 1: write enable, registered.
- `dmem_addr_o` out 32: word address, with `ALUResultM[31:2]` and bits [1:0] forced to 00; registered.
- `dmem_be_o` out 4: byte enables, registered.
- `dmem_wdata_o` out 32: lane-replicated store data, registered.
- `dmem_gnt_i` in 1: request accepted.
- `dmem_rvalid_i` in 1: response valid. Used for both load data and store acknowledge.
- `dmem_rdata_i` in 32: read data.
- `dmem_err_i` in 1: error, qualified by `dmem_rvalid_i`.

## Operation
- An access is `ValidM & (MemReadM | MemWriteM)`.
- Misalignment rules:
  - H/HU with `addr[0]=1` is misaligned.
  - W with `addr[1:0]≠0` is misaligned.
  - On a misaligned access, raise `LoadMisalignM` or `StoreMisalignM` combinationally, issue no bus request, and do not stall.
- Unsupported `Funct3M`:
  - Loads: 3, 6, 7. Stores: any value ≥3.
  - Raise `AccessFaultM` combinationally, issue no bus request, and do not stall.
- Byte enables and store data:
  - B: `be = 1<<addr[1:0]`, `wdata = {4{WriteDataM[7:0]}}`.
  - H: `be = addr[1] ? 1100 : 0011`, `wdata = {2{WriteDataM[15:0]}}`.
  - W: `be = 1111`, `wdata = WriteDataM`.
  - Loads drive the same `be`, with `dmem_we_o=0`.
- Load formatting:
  - `lane = dmem_rdata_i >> (8*addr[1:0])`.
  - B and H sign-extend; BU and HU zero-extend; W passes through.
  - The result is captured into `RdataM` on the response.
- FSM states: IDLE, REQ, WAIT, RESP.
  - **IDLE:** on a legal access, `StallM=1`. On the next edge, register the bus outputs with `dmem_req_o=1`, clear the timeout counter, and go to REQ.
  - **REQ:** `StallM=1`, `dmem_req_o` held at 1.
    - If `dmem_gnt_i`: drop `dmem_req_o` and go to WAIT.
    - Else if the counter reaches `MAX_WAIT`: drop the request, set the fault, and go to RESP.
  - **WAIT:** `StallM=1`.
    - If `dmem_rvalid_i`: capture the formatted data (loads only; stores leave `RdataM` unchanged), capture `dmem_err_i` into the fault, and go to RESP.
    - Else if the counter reaches `MAX_WAIT`: set the fault, set `RdataM` to 0 (loads), and go to RESP.
  - **RESP:** `StallM=0`. `AccessFaultM` equals the captured fault. The instruction advances at this edge. Always go to IDLE.
- The pipeline inputs are stable during REQ and WAIT, because the stall holds them.
- A `dmem_rvalid_i` or `dmem_gnt_i` arriving in IDLE or RESP is ignored.

## Timing
- Reset state:
  - FSM in IDLE, counter 0.
  - `RdataM`, `dmem_req_o`, `dmem_we_o`, `dmem_addr_o`, `dmem_be_o`, `dmem_wdata_o` all 0.
  - The captured fault is 0.
  - `StallM` and the misalignment flags follow their combinational rules.
- Reset mid-transaction aborts immediately: `dmem_req_o` goes to 0 asynchronously and the FSM returns to IDLE. Late responses are ignored.
- Minimum latency, with grant in the first REQ cycle and rvalid in the first WAIT cycle:
  - Cycle 0 (IDLE), 1 (REQ), 2 (WAIT) have `StallM=1`.
  - Cycle 3 (RESP) has `StallM=0`, with `RdataM` valid.
- Each additional grant or response wait cycle adds one stall cycle.
- Simultaneous events:
  - Grant and timeout in the same cycle: grant wins.
  - rvalid and timeout in the same cycle: rvalid wins.
- `dmem_req_o` is never high in WAIT, RESP, or IDLE.
- Back-to-back accesses: RESP→IDLE, and the next access sees a one-cycle stall in IDLE.

## Test plan
- **LB, no wait.** Setup: addr `0x1003`, `dmem_rdata_i=0x80AA_BBCC`, grant and rvalid immediate. Expect: `be=1000`, addr `0x1000`, `RdataM=0xFFFF_FF80` in the RESP cycle, 3 stall cycles.
- **SH.** Setup: addr `0x2002`, `WriteDataM=0x1234_5678`. Expect: `dmem_we_o=1`, `be=1100`, `wdata=0x5678_5678`, `RdataM` unchanged.
- **Misaligned.** Setup: LW at `0x2001`, then SH at `0x2003`. Expect: `LoadMisalignM=1`, then `StoreMisalignM=1`, with `StallM=0` and `dmem_req_o=0` throughout.
- **Grant wait + bus error.** Setup: LHU with 4 cycles of no grant, then rvalid carrying `dmem_err_i=1`. Expect: 7 stall cycles, then `AccessFaultM=1` in RESP.
- **Timeout.** Setup: `MAX_WAIT=4`, grant given, rvalid never arrives. Expect: RESP after 4 counted cycles, `AccessFaultM=1`, `RdataM=0`. A later stray rvalid is ignored.
- **Reset mid-WAIT.** Setup: assert `rst_n=0` during WAIT. Expect: all registered outputs are 0 and the FSM is in IDLE. A fresh LW then completes normally.
